// File: rtl/io_host_bridge.sv
// Host bridge: registered host-to-CPU port with a hold-off timer, plus a FIFO
// that captures every change of the CPU output port for the host to read.
module io_host_bridge #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              cpu_out,
    output logic [15:0]              cpu_in,
    input  logic                     h_wr_valid,
    input  logic [15:0]              h_wr_data,
    output logic                     h_wr_ready,
    output logic                     h_rd_valid,
    output logic [15:0]              h_rd_data,
    input  logic                     h_rd_ready,
    output logic [$clog2(DEPTH):0]   ofifo_count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = 4;

    logic [15:0]   cpu_in_q, cpu_in_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          ready_q, ready_d;
    logic [15:0]   prev_q;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   mem_q [DEPTH];

    logic wr_fire;
    logic push;
    logic pop;
    logic full;
    logic push_ok;

    always_comb begin
        wr_fire  = h_wr_valid && ready_q;
        cpu_in_d = cpu_in_q;
        hold_d   = hold_q;
        if (wr_fire) begin
            cpu_in_d = h_wr_data;
            hold_d   = HW'(HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end
        // Ready is registered from the next counter value so it drops right after a transfer.
        ready_d = (hold_d == '0);
    end

    always_comb begin
        push    = (cpu_out != prev_q);
        pop     = (count_q != '0) && h_rd_ready;
        full    = (count_q == CW'(DEPTH));
        // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
        push_ok = push && (!full || pop);
        wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_in_q <= '0;
            hold_q   <= '0;
            ready_q  <= 1'b1;
            prev_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cpu_in_q <= cpu_in_d;
            hold_q   <= hold_d;
            ready_q  <= ready_d;
            prev_q   <= cpu_out;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wptr_q] <= cpu_out;
        end
    end

    assign cpu_in      = cpu_in_q;
    assign h_wr_ready  = ready_q;
    assign h_rd_valid  = (count_q != '0);
    assign h_rd_data   = mem_q[rptr_q];
    assign ofifo_count = count_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/io_host_bridge.md
IO_HOST_BRIDGE -- requirements
Module: io_host_bridge

Interface
REQ-001 Parameter DEPTH, 4, output FIFO entries; power of two, 2..16.
REQ-002 Parameter HOLD, 4, cycles h_wr_ready stays low after an accepted host write; 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_out  input  16  CPU output port value, level, sampled every cycle.
REQ-006 cpu_in  output  16  registered word driven onto the CPU input port.
REQ-007 h_wr_valid  input  1  host offers a word for cpu_in.
REQ-008 h_wr_data  input  16  host word for cpu_in.
REQ-009 h_wr_ready  output  1  bridge accepts a host word this cycle.
REQ-010 h_rd_valid  output  1  FIFO head word available to host.
REQ-011 h_rd_data  output  16  FIFO head word.
REQ-012 h_rd_ready  input  1  host consumes head word this cycle.
REQ-013 ofifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky flag: at least one captured word was dropped.
REQ-015 The clock and reset are one clock, synchronous active-high reset, named clk and reset.

Function
REQ-016 The host-write transfer SHALL occur on a rising edge where h_wr_valid and h_wr_ready are both 1; cpu_in SHALL take h_wr_data at that edge.
REQ-017 cpu_in SHALL hold its value between transfers; no other event alters it.
REQ-018 After a transfer, a hold counter SHALL load HOLD and h_wr_ready SHALL be 0 for exactly HOLD cycles, returning to 1 on the following cycle.
REQ-019 h_wr_ready SHALL be a registered function of the hold counter only (1 when counter is 0), independent of h_wr_valid.
REQ-020 The bridge SHALL keep a register prev_out updated with cpu_out every cycle.
REQ-021 A capture event SHALL occur on any edge where cpu_out != prev_out; the current cpu_out value is the pushed word.
REQ-022 A pop SHALL occur on any edge where h_rd_valid and h_rd_ready are both 1.
REQ-023 h_rd_valid SHALL equal (ofifo_count != 0); h_rd_data SHALL be the oldest entry, valid whenever h_rd_valid is 1, don't-care otherwise.
REQ-024 FIFO order SHALL be strict first-in first-out; read/write pointers wrap modulo DEPTH.
REQ-025 Capture latency: word pushed at edge k SHALL be visible (h_rd_valid=1 if FIFO was empty) immediately after edge k.
REQ-026 Push without pop, not full: count +1. Pop without push: count -1. Push and pop same edge: both performed, count unchanged.
REQ-027 Push while full with simultaneous pop: push accepted, no overflow.
REQ-028 Push while full without pop: word dropped, FIFO unchanged, overflow set to 1.
REQ-029 overflow SHALL remain 1 until reset; no other clear path.
REQ-030 Pop while empty SHALL be impossible (h_rd_valid=0); h_rd_ready ignored when empty.
REQ-031 Back-to-back changes of cpu_out on consecutive cycles SHALL each produce one push.

Reset
REQ-032 On a reset edge: cpu_in=0x0000, prev_out=0x0000, FIFO pointers and ofifo_count=0, h_rd_valid=0, overflow=0, hold counter=0 so h_wr_ready=1 after the edge.
REQ-033 Reset SHALL take priority over any simultaneous transfer, capture or pop; FIFO contents are discarded.
REQ-034 Because prev_out resets to 0, a nonzero cpu_out present on the first post-reset edge SHALL be captured.

Verification
REQ-035 Host write: reset, h_wr_valid=1 data 0x1234 -> cpu_in=0x1234 next cycle, h_wr_ready=0 for 4 cycles, then 1; second word 0xBEEF held pending until ready, then cpu_in=0xBEEF.
REQ-036 Capture/order: cpu_out steps 0x0001,0x0002,0x0003 on consecutive cycles, h_rd_ready=0 -> ofifo_count=3; then h_rd_ready=1 -> h_rd_data 0x0001,0x0002,0x0003 in order, then h_rd_valid=0.
REQ-037 No-change: cpu_out held at 0x00AA for 10 cycles after one capture -> exactly one entry.
REQ-038 Overflow: 5 distinct cpu_out values, no pops, DEPTH=4 -> count=4, overflow=1, FIFO holds first four; stays 1 after draining.
REQ-039 Full push+pop: FIFO full, cpu_out changes to 0x5555 while h_rd_ready=1 -> count stays 4, overflow=0, 0x5555 last out.
REQ-040 Mid-operation reset: FIFO at 2 entries, hold counter active, assert reset 1 cycle with cpu_out=0x0007 -> all REQ-032 values; next edge captures 0x0007, count=1.
